// File: rtl/jlsemi_util_clkmux_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jlsemi_util_clkmux_switch_ctrl
// Brief    : Glitch-free runtime source switch sequencer for a 2:1 clock mux.
//            Gates the mux output, changes select, settles, then re-enables.
// Revision : 1.0 - initial release
// ============================================================================
module jlsemi_util_clkmux_switch_ctrl #(
    parameter int   GATE_WAIT   = 4,
    parameter int   SETTLE_WAIT = 8,
    parameter int   CNT_W       = 4,
    parameter logic RESET_SEL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    input  logic req_sel_i,
    input  logic dft_test_clk_en,
    output logic sel_o,
    output logic clk_gate_en_o,
    output logic busy_o,
    output logic done_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GATE_OFF = 2'd1;
    localparam logic [1:0] S_SWITCH   = 2'd2;
    localparam logic [1:0] S_SETTLE   = 2'd3;

    localparam logic [CNT_W-1:0] C_GATE_LAST   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_WAIT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_target;
    logic             r_sel;
    logic             r_gate_en;
    logic             r_done;

    logic w_accept;
    logic w_start;
    logic w_noop;
    logic w_gate_last;
    logic w_settle_last;

    // Requests are only looked at in IDLE; anything arriving while busy is dropped.
    assign w_accept      = (r_state == S_IDLE) && req_i && !dft_test_clk_en;
    assign w_start       = w_accept && (req_sel_i != r_sel);
    assign w_noop        = w_accept && (req_sel_i == r_sel);
    assign w_gate_last   = (r_cnt == C_GATE_LAST);
    assign w_settle_last = (r_cnt == C_SETTLE_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_target  <= RESET_SEL;
            r_sel     <= RESET_SEL;
            r_gate_en <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_target  <= req_sel_i;
                        r_gate_en <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_GATE_OFF;
                    end else if (w_noop) begin
                        r_done <= 1'b1;
                    end
                end
                S_GATE_OFF: begin
                    if (w_gate_last) begin
                        r_cnt   <= '0;
                        r_state <= S_SWITCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SWITCH: begin
                    // Select only moves here, strictly inside the gated-off window.
                    r_sel   <= r_target;
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (w_settle_last) begin
                        r_cnt     <= '0;
                        r_gate_en <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sel_o         = r_sel;
    assign clk_gate_en_o = r_gate_en | dft_test_clk_en;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_jlsemi_util_clkmux_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jlsemi_util_clkmux_switch_ctrl
// Brief    : Directed + random stimulus against a cycle-offset reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jlsemi_util_clkmux_switch_ctrl;

    localparam int   G  = 4;
    localparam int   S  = 8;
    localparam int   CW = 4;
    localparam logic RS = 1'b0;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic req      = 1'b0;
    logic req_sel  = 1'b0;
    logic dft      = 1'b0;
    logic sel;
    logic gate;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    // Model: a switch is described by k = cycles since its acceptance edge.
    bit   m_active;
    bit   m_noop_done;
    int   m_k;
    logic m_sel;
    logic m_new_sel;

    jlsemi_util_clkmux_switch_ctrl #(
        .GATE_WAIT  (G),
        .SETTLE_WAIT(S),
        .CNT_W      (CW),
        .RESET_SEL  (RS)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_i          (req),
        .req_sel_i      (req_sel),
        .dft_test_clk_en(dft),
        .sel_o          (sel),
        .clk_gate_en_o  (gate),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_busy();
        return m_active && (m_k >= 1) && (m_k <= G + S + 1);
    endfunction

    task automatic model_reset();
        m_active    = 1'b0;
        m_noop_done = 1'b0;
        m_k         = 0;
        m_sel       = RS;
        m_new_sel   = RS;
    endtask

    task automatic model_edge();
        bit b;
        b = exp_busy();
        m_noop_done = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!b && req && !dft && (req_sel != m_sel)) begin
            m_active  = 1'b1;
            m_k       = 1;
            m_new_sel = req_sel;
        end else begin
            if (!b && req && !dft) m_noop_done = 1'b1;
            if (m_active) m_k++;
            if (m_active && m_k == G + 2) m_sel = m_new_sel;
            if (m_active && m_k > G + S + 2) m_active = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("sel", sel, m_sel);
        chk("busy", busy, exp_busy());
        chk("gate", gate, !exp_busy() || dft);
        chk("done", done, (m_active && m_k == G + S + 2) || m_noop_done);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk) rst_n = 1'b1;

        // idle after reset
        run(10);

        // no-op request with matching select
        req = 1'b1; req_sel = 1'b0;
        cyc();
        req = 1'b0;
        run(3);

        // full switch 0 -> 1
        req = 1'b1; req_sel = 1'b1;
        cyc();
        req = 1'b0;
        run(16);

        // no-op at select 1, then switch back to 0
        req = 1'b1; req_sel = 1'b1;
        cyc();
        req = 1'b0; run(2);
        req = 1'b1; req_sel = 1'b0;
        cyc();
        req = 1'b0;
        run(16);

        // 0 -> 1, with a 1 -> 0 request held from cycle 5 through the done cycle
        req = 1'b1; req_sel = 1'b1;
        cyc();
        req = 1'b0;
        run(4);
        req = 1'b1; req_sel = 1'b0;
        run(10);
        req = 1'b0;
        run(16);

        // asynchronous reset in SETTLE (cycle 9)
        req = 1'b1; req_sel = 1'b1;
        cyc();
        req = 1'b0;
        run(8);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cyc();
        @(negedge clk) rst_n = 1'b1;
        run(16);

        // DFT mode blocks new requests in IDLE
        dft = 1'b1; req = 1'b1; req_sel = 1'b1;
        cyc();
        req = 1'b0;
        run(3);
        dft = 1'b0;
        run(2);

        // DFT asserted mid GATE_OFF: gate forced high, sequence still completes
        req = 1'b1; req_sel = 1'b1;
        cyc();
        req = 1'b0;
        cyc();
        dft = 1'b1;
        #1;
        check_outputs();
        run(14);
        dft = 1'b0;
        run(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            req     = ($urandom_range(0, 3) == 0);
            req_sel = $urandom_range(0, 1);
            dft     = ($urandom_range(0, 9) == 0);
            cyc();
        end
        req = 1'b0; dft = 1'b0;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
